// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory stage load/store unit.
// Access-size decode, byte enables, store lane steering and load extension.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  function automatic logic is_aligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic ok;
    unique case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~lo[0];
      default: ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic [3:0] be;
    unique case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-aligned data so every candidate lane carries it.
  function automatic logic [31:0] store_lanes(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] d;
    unique case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [2:0]  f3,
    input logic [1:0]  lo,
    input logic [31:0] word
  );
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lo, 3'b000};
    unique case (1'b1)
      (f3 == F3_B):  res = {{24{sh[7]}}, sh[7:0]};
      (f3 == F3_BU): res = {24'h0, sh[7:0]};
      (f3 == F3_H):  res = {{16{sh[15]}}, sh[15:0]};
      (f3 == F3_HU): res = {16'h0, sh[15:0]};
      default:       res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_ram_be.sv
// Word-wide data RAM with per-byte write enables.
// Synchronous write, registered read updated only when re is set.
module data_ram_be #(
  parameter int    ADDR_BITS = 12,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [3:0]           be,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_stage_lsu.sv
// Memory pipeline stage: multi-cycle load/store unit with stall FSM.
// Control fields from E/M pass straight through to M/W.
module memory_stage_lsu
  import mem_pkg::*;
#(
  parameter int    WIDTH     = 32,
  parameter int    ADDR_BITS = 12,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result_m_i,
  input  logic [WIDTH-1:0] write_data_m_i,
  input  logic             mem_write_m_i,
  input  logic             mem_read_m_i,
  input  logic [2:0]       funct3_m_i,
  input  logic             reg_write_m_i,
  input  logic [1:0]       result_src_m_i,
  input  logic [4:0]       rd_m_i,
  input  logic [WIDTH-1:0] pc_plus_4_m_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic             stall_o,
  output logic             misaligned_o,
  output logic             reg_write_m_o,
  output logic [1:0]       result_src_m_o,
  output logic [4:0]       rd_m_o,
  output logic [WIDTH-1:0] pc_plus_4_m_o,
  output logic [WIDTH-1:0] alu_result_m_o
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            stall, mis, commit;
  logic            is_store, req, ok;
  logic [1:0]      lo;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]     ram_q;
  logic            ld_valid;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_lo;

  assign lo       = alu_result_m_i[1:0];
  assign idx      = alu_result_m_i[ADDR_BITS+1:2];
  assign is_store = mem_write_m_i;
  assign req      = mem_write_m_i | mem_read_m_i;
  assign ok       = is_aligned(funct3_m_i, lo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    mis     = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && !ok) begin
          mis = 1'b1;
        end else if (req) begin
          stall = 1'b1;
          cnt_n = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_n = cnt - CW'(1);
        // Counter reaching zero marks the final stall cycle.
        if (cnt_n == '0) begin
          commit  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (rst) begin
      stall  = 1'b0;
      mis    = 1'b0;
      commit = 1'b0;
    end
  end

  data_ram_be #(
    .ADDR_BITS (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (commit & is_store),
    .re    (commit & ~is_store),
    .be    (byte_en(funct3_m_i, lo)),
    .addr  (idx),
    .wdata (store_lanes(funct3_m_i, write_data_m_i)),
    .rdata (ram_q)
  );

  // Size and offset captured with the word so the result holds after the op.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_valid <= 1'b0;
      ld_f3    <= '0;
      ld_lo    <= '0;
    end else if (commit && !is_store) begin
      ld_valid <= 1'b1;
      ld_f3    <= funct3_m_i;
      ld_lo    <= lo;
    end
  end

  assign read_data_o    = ld_valid ? load_ext(ld_f3, ld_lo, ram_q) : '0;
  assign stall_o        = stall;
  assign misaligned_o   = mis;
  assign reg_write_m_o  = reg_write_m_i;
  assign result_src_m_o = result_src_m_i;
  assign rd_m_o         = rd_m_i;
  assign pc_plus_4_m_o  = pc_plus_4_m_i;
  assign alu_result_m_o = alu_result_m_i;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Bench for memory_stage_lsu: three instances at LATENCY 2, 3 and 1,
// checked against a byte-level reference model of memory and load results.
module tb_memory_stage_lsu;

  typedef struct packed {
    logic        st;
    logic        ld;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] want;
    logic        chk;
  } op_t;

  logic        clk;
  logic        rst [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic        mw [3];
  logic        mr [3];
  logic [2:0]  f3 [3];
  logic        rw [3];
  logic [1:0]  rs [3];
  logic [4:0]  rdi [3];
  logic [31:0] pc [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        mis [3];
  logic        rw_o [3];
  logic [1:0]  rs_o [3];
  logic [4:0]  rdo [3];
  logic [31:0] pc_o [3];
  logic [31:0] alu_o [3];

  int          lat [3] = '{2, 3, 1};
  logic [31:0] mdl [3][4096];
  logic [31:0] last [3];
  int          total = 0;
  int          bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 3 : 1;
    memory_stage_lsu #(.LATENCY(L)) u_dut (
      .clk            (clk),
      .rst            (rst[g]),
      .alu_result_m_i (addr[g]),
      .write_data_m_i (wdata[g]),
      .mem_write_m_i  (mw[g]),
      .mem_read_m_i   (mr[g]),
      .funct3_m_i     (f3[g]),
      .reg_write_m_i  (rw[g]),
      .result_src_m_i (rs[g]),
      .rd_m_i         (rdi[g]),
      .pc_plus_4_m_i  (pc[g]),
      .read_data_o    (rdata[g]),
      .stall_o        (stall[g]),
      .misaligned_o   (mis[g]),
      .reg_write_m_o  (rw_o[g]),
      .result_src_m_o (rs_o[g]),
      .rd_m_o         (rdo[g]),
      .pc_plus_4_m_o  (pc_o[g]),
      .alu_result_m_o (alu_o[g])
    );
  end

  function automatic op_t mk(input logic st, input logic ld,
                             input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] want,
                             input logic chk);
    return '{st: st, ld: ld, f: f, a: a, wd: wd, want: want, chk: chk};
  endfunction

  task automatic drive_pt(input int k);
    rw[k]  = 1'($urandom);
    rs[k]  = 2'($urandom);
    rdi[k] = 5'($urandom);
    pc[k]  = $urandom;
  endtask

  // Reference: little-endian byte memory, size/offset rules, extension.
  task automatic model_step(input int k, input logic st, input logic ld,
                            input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] er,
                            output int en, output logic em);
    int sz, off;
    logic [31:0] w, v;
    sz  = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    en  = 0;
    em  = 1'b0;
    er  = last[k];
    if (!(st || ld)) return;
    if ((off % sz) != 0) begin
      em = 1'b1;
      return;
    end
    en = lat[k];
    w  = mdl[k][a[13:2]];
    if (st) begin
      for (int i = 0; i < sz; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
      mdl[k][a[13:2]] = w;
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
      if (!f[2] && sz < 4 && v[8*sz-1]) begin
        for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      er = v;
      last[k] = v;
    end
  endtask

  // Presents one instruction and holds it until stall drops.
  task automatic xact(input int k, input logic st, input logic ld,
                      input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] r,
                      output logic [31:0] er, output int n, output int en,
                      output logic m, output logic em, output int ptb,
                      output bit to);
    model_step(k, st, ld, f, a, wd, er, en, em);
    mw[k] = st; mr[k] = ld; f3[k] = f; addr[k] = a; wdata[k] = wd;
    drive_pt(k);
    n = 0; ptb = 0; to = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if ({rw_o[k], rs_o[k], rdo[k], pc_o[k], alu_o[k]} !==
          {rw[k], rs[k], rdi[k], pc[k], addr[k]}) ptb++;
      if (stall[k] === 1'b1) begin
        n++;
        @(posedge clk); #1;
        drive_pt(k);
      end else begin
        to = 1'b0;
        break;
      end
    end
    r = rdata[k];
    m = mis[k];
    @(posedge clk); #1;
    mw[k] = 1'b0; mr[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; mw[k] = 1'b0; mr[k] = 1'b0; f3[k] = 3'b010;
      addr[k] = '0; wdata[k] = '0; last[k] = '0;
      drive_pt(k);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({stall[k], mis[k], rdata[k]} !== 34'h0) begin
        bad++;
        $display("FAIL reset%0d: stall=%b mis=%b rd=%h want 0 0 0",
                 k, stall[k], mis[k], rdata[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    op_t ops[$];
    logic [31:0] r, er; int n, en, ptb; logic m, em; bit to;
    ops.push_back(mk(1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0));
    ops.push_back(mk(0, 1, 3'b010, 32'h10, 0, 32'hDEADBEEF, 1));
    foreach (ops[i]) begin
      xact(0, ops[i].st, ops[i].ld, ops[i].f, ops[i].a, ops[i].wd,
           r, er, n, en, m, em, ptb, to);
      total++;
      if (r !== er || n != en || m !== em || ptb != 0 || to ||
          (ops[i].chk && r !== ops[i].want)) begin
        bad++;
        $display("FAIL store_load%0d: rd=%h want %h stalls=%0d want %0d mis=%b want %b pt=%0d to=%0d",
                 i, r, er, n, en, m, em, ptb, to);
      end
    end
  endtask

  task automatic test_byte_lanes();
    op_t ops[$];
    logic [31:0] r, er; int n, en, ptb; logic m, em; bit to;
    ops.push_back(mk(1, 0, 3'b000, 32'h11, 32'h0000007F, 0, 0));
    ops.push_back(mk(0, 1, 3'b010, 32'h10, 0, 32'hDEAD7FEF, 1));
    ops.push_back(mk(0, 1, 3'b000, 32'h13, 0, 32'hFFFFFFDE, 1));
    ops.push_back(mk(0, 1, 3'b100, 32'h13, 0, 32'h000000DE, 1));
    ops.push_back(mk(0, 1, 3'b001, 32'h12, 0, 32'hFFFFDEAD, 1));
    ops.push_back(mk(0, 1, 3'b101, 32'h12, 0, 32'h0000DEAD, 1));
    foreach (ops[i]) begin
      xact(0, ops[i].st, ops[i].ld, ops[i].f, ops[i].a, ops[i].wd,
           r, er, n, en, m, em, ptb, to);
      total++;
      if (r !== er || n != en || m !== em || ptb != 0 || to ||
          (ops[i].chk && r !== ops[i].want)) begin
        bad++;
        $display("FAIL byte_lanes%0d: rd=%h want %h stalls=%0d want %0d mis=%b want %b pt=%0d to=%0d",
                 i, r, er, n, en, m, em, ptb, to);
      end
    end
  endtask

  task automatic test_misaligned();
    op_t ops[$];
    logic [31:0] r, er; int n, en, ptb; logic m, em; bit to;
    ops.push_back(mk(0, 1, 3'b010, 32'h12, 0, 32'h0000DEAD, 1));
    ops.push_back(mk(1, 0, 3'b001, 32'h11, 32'h0000BEEF, 32'h0000DEAD, 1));
    ops.push_back(mk(1, 0, 3'b010, 32'h13, 32'h01020304, 32'h0000DEAD, 1));
    ops.push_back(mk(0, 1, 3'b010, 32'h10, 0, 32'hDEAD7FEF, 1));
    foreach (ops[i]) begin
      xact(0, ops[i].st, ops[i].ld, ops[i].f, ops[i].a, ops[i].wd,
           r, er, n, en, m, em, ptb, to);
      total++;
      if (r !== er || n != en || m !== em || ptb != 0 || to ||
          (ops[i].chk && r !== ops[i].want)) begin
        bad++;
        $display("FAIL misaligned%0d: rd=%h want %h stalls=%0d want %0d mis=%b want %b pt=%0d to=%0d",
                 i, r, er, n, en, m, em, ptb, to);
      end
    end
  endtask

  task automatic test_wrap();
    op_t ops[$];
    logic [31:0] r, er; int n, en, ptb; logic m, em; bit to;
    ops.push_back(mk(1, 0, 3'b010, 32'h4000, 32'hA5A5A5A5, 0, 0));
    ops.push_back(mk(0, 1, 3'b010, 32'h0000, 0, 32'hA5A5A5A5, 1));
    ops.push_back(mk(0, 1, 3'b010, 32'hFFFF0010, 0, 32'hDEAD7FEF, 1));
    foreach (ops[i]) begin
      xact(0, ops[i].st, ops[i].ld, ops[i].f, ops[i].a, ops[i].wd,
           r, er, n, en, m, em, ptb, to);
      total++;
      if (r !== er || n != en || m !== em || ptb != 0 || to ||
          (ops[i].chk && r !== ops[i].want)) begin
        bad++;
        $display("FAIL wrap%0d: rd=%h want %h stalls=%0d want %0d mis=%b want %b pt=%0d to=%0d",
                 i, r, er, n, en, m, em, ptb, to);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, er; int n, en, ptb; logic m, em; bit to;
    xact(1, 1, 0, 3'b010, 32'h20, 32'h11111111, r, er, n, en, m, em, ptb, to);
    xact(1, 0, 1, 3'b010, 32'h20, 0, r, er, n, en, m, em, ptb, to);
    total++;
    if (r !== 32'h11111111 || n != 3 || to) begin
      bad++;
      $display("FAIL rmid_pre: rd=%h want 11111111 stalls=%0d want 3", r, n);
    end
    mw[1] = 1'b1; mr[1] = 1'b0; f3[1] = 3'b010;
    addr[1] = 32'h20; wdata[1] = 32'h12345678;
    @(negedge clk);
    total++;
    if (stall[1] !== 1'b1) begin
      bad++;
      $display("FAIL rmid_stall: stall=%b want 1", stall[1]);
    end
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0; mw[1] = 1'b0;
    last[1] = '0;
    @(negedge clk);
    total++;
    if ({stall[1], mis[1], rdata[1]} !== 34'h0) begin
      bad++;
      $display("FAIL rmid_after: stall=%b mis=%b rd=%h want 0 0 0",
               stall[1], mis[1], rdata[1]);
    end
    @(posedge clk); #1;
    xact(1, 0, 1, 3'b010, 32'h20, 0, r, er, n, en, m, em, ptb, to);
    total++;
    if (r !== er || r !== 32'h11111111 || n != en || to) begin
      bad++;
      $display("FAIL rmid_load: rd=%h want 11111111 stalls=%0d want %0d",
               r, n, en);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, er; int n, en, ptb; logic m, em; bit to;
    logic [31:0] a, d;
    logic [2:0] ldf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 12; i++) begin
      a = 32'h40 + 32'(4 * (i / 2));
      d = $urandom;
      if (i % 2 == 0)
        xact(2, 1, 0, 3'b010, a, d, r, er, n, en, m, em, ptb, to);
      else
        xact(2, 0, 1, ldf[i % 5], a + 32'(i % 2) * 0, 0,
             r, er, n, en, m, em, ptb, to);
      total++;
      if (r !== er || n != 1 || m !== em || ptb != 0 || to) begin
        bad++;
        $display("FAIL b2b%0d: rd=%h want %h stalls=%0d want 1 mis=%b pt=%0d to=%0d",
                 i, r, er, n, m, ptb, to);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, er; int n, en, ptb; logic m, em; bit to;
    logic [31:0] a;
    logic [2:0] f;
    logic st, ld;
    int kind;
    logic [2:0] ldf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFFC000) | 32'(i << 2);
      xact(0, 1, 0, 3'b010, a, $urandom, r, er, n, en, m, em, ptb, to);
    end
    for (int i = 0; i < 150; i++) begin
      a = ($urandom & 32'hFFFFC000) | 32'(($urandom % 16) << 2)
          | 32'($urandom % 4);
      kind = int'($urandom % 8);
      st = (kind < 3) || (kind == 7);
      ld = (kind >= 3);
      f  = st ? 3'(kind % 3) : ldf[$urandom % 5];
      if (kind == 6) begin
        st = 1'b0; ld = 1'b0;
      end
      xact(0, st, ld, f, a, $urandom, r, er, n, en, m, em, ptb, to);
      total++;
      if (r !== er || n != en || m !== em || ptb != 0 || to) begin
        bad++;
        $display("FAIL rand%0d: st=%b ld=%b f3=%b a=%h rd=%h want %h stalls=%0d want %0d mis=%b want %b pt=%0d",
                 i, st, ld, f, a, r, er, n, en, m, em, ptb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
